// File: rtl/bitserial_pkg.sv
// rtl/bitserial_pkg.sv - shared FSM state encoding for the bit-serial operand link
package bitserial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/bitserial_hold_reg.sv
// rtl/bitserial_hold_reg.sv - one-entry valid/ready holding register
module bitserial_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // The owner guarantees push and pop never coincide, so push simply wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (push) begin
            r_valid <= 1'b1;
            r_data  <= push_data;
        end else if (pop) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule

// File: rtl/bitserial_operand_serializer.sv
// rtl/bitserial_operand_serializer.sv - start pulse, parallel mcand and LSB-first serial mplier
module bitserial_operand_serializer
    import bitserial_pkg::*;
#(
    parameter int MCAND_WIDTH  = 16,
    parameter int MPLIER_WIDTH = 16,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MCAND_WIDTH-1:0]  in_mcand,
    input  logic [MPLIER_WIDTH-1:0] in_mplier,
    output logic                    start_out,
    output logic [MCAND_WIDTH-1:0]  mcand_out,
    output logic [MPLIER_WIDTH-1:0] mplier_out,
    output logic                    ser_bit,
    output logic                    busy
);

    localparam int HW = MCAND_WIDTH + MPLIER_WIDTH;
    localparam int CW = $clog2(MPLIER_WIDTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(MPLIER_WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES - 1);

    state_t                  r_state;
    logic                    r_run;
    logic [MPLIER_WIDTH-1:0] r_shreg;
    logic [CW-1:0]           r_bit_cnt;
    logic [GW-1:0]           r_gap_cnt;
    logic                    r_start;
    logic                    r_ser;
    logic                    r_busy;
    logic [MCAND_WIDTH-1:0]  r_mcand;
    logic [MPLIER_WIDTH-1:0] r_mplier;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_hold_valid;
    logic [HW-1:0]           w_hold_data;

    // r_run keeps in_ready low until the first edge after reset release.
    assign in_ready = r_run & ~w_hold_valid;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = w_hold_valid &
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_GAP) && (r_gap_cnt == LAST_GAP)));

    bitserial_hold_reg #(
        .WIDTH(HW)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_push),
        .push_data({in_mcand, in_mplier}),
        .pop      (w_pop),
        .valid    (w_hold_valid),
        .data     (w_hold_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_run     <= 1'b0;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_start   <= 1'b0;
            r_ser     <= 1'b0;
            r_busy    <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_pop) begin
                r_mcand  <= w_hold_data[HW-1:MPLIER_WIDTH];
                r_mplier <= w_hold_data[MPLIER_WIDTH-1:0];
                r_shreg  <= w_hold_data[MPLIER_WIDTH-1:0];
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_start   <= 1'b0;
                    r_ser     <= r_shreg[0];
                    r_shreg   <= r_shreg >> 1;
                    r_bit_cnt <= '0;
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        r_ser     <= 1'b0;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end else begin
                        r_ser     <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == LAST_GAP) begin
                        if (w_hold_valid) begin
                            r_start <= 1'b1;
                            r_state <= ST_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign start_out  = r_start;
    assign ser_bit    = r_ser;
    assign busy       = r_busy;
    assign mcand_out  = r_mcand;
    assign mplier_out = r_mplier;

endmodule

// File: tb/tb_bitserial_operand_serializer.sv
// tb/tb_bitserial_operand_serializer.sv - randomized bench with operation-level reference model
module tb_bitserial_operand_serializer;

    localparam int MW     = 16;
    localparam int PW     = 16;
    localparam int GAP    = 2;
    localparam int PERIOD = 1 + PW + GAP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid = 1'b0;
    logic [MW-1:0] in_mcand = '0;
    logic [PW-1:0] in_mplier = '0;
    logic          in_ready;
    logic          start_out;
    logic [MW-1:0] mcand_out;
    logic [PW-1:0] mplier_out;
    logic          ser_bit;
    logic          busy;

    always #5 clk = ~clk;

    bitserial_operand_serializer #(
        .MCAND_WIDTH (MW),
        .MPLIER_WIDTH(PW),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mcand  (in_mcand),
        .in_mplier (in_mplier),
        .start_out (start_out),
        .mcand_out (mcand_out),
        .mplier_out(mplier_out),
        .ser_bit   (ser_bit),
        .busy      (busy)
    );

    typedef struct {
        logic [MW-1:0] mc;
        logic [PW-1:0] mp;
        logic [PW-1:0] ser;
        int            t;
    } op_t;

    typedef struct {
        logic [MW-1:0] mc;
        logic [PW-1:0] mp;
        int            t;
    } xfer_t;

    op_t   obs_q[$];
    xfer_t acc_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    stray = 0;
    int    unstable = 0;
    int    overlap = 0;
    int    start_cnt = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observer: rebuilds each operation from the pins; a transfer seen here lands on edge cyc+1.
    initial begin
        op_t cur;
        int  nb;
        int  ng;
        bit  act;
        act = 1'b0;
        nb  = 0;
        ng  = 0;
        cur.mc = '0; cur.mp = '0; cur.ser = '0; cur.t = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 1'b0;
            end else begin
                if (act) begin
                    if (mcand_out !== cur.mc || mplier_out !== cur.mp) unstable++;
                    if (nb < PW) begin
                        cur.ser[nb] = ser_bit;
                        nb++;
                        if (nb == PW) obs_q.push_back(cur);
                    end else begin
                        if (ser_bit !== 1'b0) stray++;
                        ng++;
                        if (ng == GAP) act = 1'b0;
                    end
                end else if (ser_bit !== 1'b0) begin
                    stray++;
                end
                if (start_out === 1'b1) begin
                    if (act) overlap++;
                    start_cnt++;
                    cur.mc  = mcand_out;
                    cur.mp  = mplier_out;
                    cur.ser = '0;
                    cur.t   = cyc;
                    act = 1'b1;
                    nb  = 0;
                    ng  = 0;
                end
                if (in_valid === 1'b1 && in_ready === 1'b1)
                    acc_q.push_back('{in_mcand, in_mplier, cyc + 1});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_books();
        obs_q.delete();
        acc_q.delete();
        stray = 0;
        unstable = 0;
        overlap = 0;
        start_cnt = 0;
    endtask

    task automatic send(input logic [MW-1:0] mc, input logic [PW-1:0] mp);
        logic rdy;
        bit   done;
        done = 1'b0;
        in_valid  = 1'b1;
        in_mcand  = mc;
        in_mplier = mp;
        for (int k = 0; k < 200 && !done; k++) begin
            rdy = in_ready;
            step();
            if (rdy) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic wait_ops(input int n, input int limit);
        for (int k = 0; k < limit && obs_q.size() < n; k++) step();
        repeat (GAP + 2) step();
        vectors++;
        if (obs_q.size() != n) begin
            miscompares++;
            $display("FAIL op_count: got %0d operations, required %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({start_out, ser_bit, busy, in_ready} !== 4'b0 || mcand_out !== '0 || mplier_out !== '0) begin
            miscompares++;
            $display("FAIL reset_initial: start=%b ser=%b busy=%b rdy=%b mc=%h mp=%h, required all 0",
                     start_out, ser_bit, busy, in_ready, mcand_out, mplier_out);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b required 0", in_ready);
        end
        step();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_release: got %b required 1", in_ready);
        end
        send(16'h1234, 16'hFFFF);
        for (int k = 0; k < 20 && start_out !== 1'b1; k++) step();
        repeat (5) step();
        vectors++;
        if (ser_bit !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_shift: ser=%b busy=%b, required 1 1", ser_bit, busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({start_out, ser_bit, busy, in_ready} !== 4'b0 || mcand_out !== '0 || mplier_out !== '0) begin
            miscompares++;
            $display("FAIL reset_async: start=%b ser=%b busy=%b rdy=%b mc=%h mp=%h, required all 0",
                     start_out, ser_bit, busy, in_ready, mcand_out, mplier_out);
        end
        step();
        step();
        rst_n = 1'b1;
        start_cnt = 0;
        step();
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: rdy=%b busy=%b, required 1 0", in_ready, busy);
        end
        repeat (PERIOD + 4) step();
        vectors++;
        if (start_cnt != 0 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_discard: starts=%0d ops=%0d, required 0 0", start_cnt, obs_q.size());
        end
        clear_books();
    endtask

    task automatic test_single();
        logic [31:0] prod;
        clear_books();
        send(16'h0003, 16'h0005);
        wait_ops(1, 100);
        if (obs_q.size() != 1 || acc_q.size() != 1) return;
        prod = obs_q[0].mc * obs_q[0].ser;
        vectors++;
        if (obs_q[0].ser !== 16'h0005 || obs_q[0].mp !== 16'h0005 || obs_q[0].mc !== 16'h0003) begin
            miscompares++;
            $display("FAIL single_bits: ser=%h mp=%h mc=%h, required 0005 0005 0003",
                     obs_q[0].ser, obs_q[0].mp, obs_q[0].mc);
        end
        vectors++;
        if (prod !== 32'h0000000F) begin
            miscompares++;
            $display("FAIL single_product: got %h required 0000000f", prod);
        end
        vectors++;
        if (obs_q[0].t != acc_q[0].t + 1) begin
            miscompares++;
            $display("FAIL single_latency: start at edge %0d, required %0d", obs_q[0].t, acc_q[0].t + 1);
        end
        vectors++;
        if (stray != 0 || start_cnt != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: stray=%0d starts=%0d busy=%b, required 0 1 0", stray, start_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] mc[3];
        logic [PW-1:0] mp[3];
        clear_books();
        for (int i = 0; i < 3; i++) begin
            mc[i] = MW'($urandom);
            mp[i] = PW'($urandom);
        end
        for (int i = 0; i < 3; i++) send(mc[i], mp[i]);
        wait_ops(3, 200);
        if (obs_q.size() != 3 || acc_q.size() != 3) return;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_q[i].mc !== mc[i] || obs_q[i].ser !== mp[i]) begin
                miscompares++;
                $display("FAIL b2b_data%0d: mc=%h ser=%h, required %h %h", i, obs_q[i].mc, obs_q[i].ser, mc[i], mp[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            vectors++;
            if (obs_q[i].t - obs_q[i-1].t != PERIOD) begin
                miscompares++;
                $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d", i, obs_q[i].t - obs_q[i-1].t, PERIOD);
            end
            vectors++;
            if (acc_q[i].t != obs_q[i-1].t + 1) begin
                miscompares++;
                $display("FAIL b2b_accept%0d: edge %0d, required %0d", i, acc_q[i].t, obs_q[i-1].t + 1);
            end
        end
    endtask

    task automatic test_extremes();
        logic [MW-1:0] mc0;
        logic [MW-1:0] mc1;
        logic [31:0]   prod;
        clear_books();
        mc0 = MW'($urandom_range(1, 16'hFFFF));
        mc1 = MW'($urandom_range(1, 16'hFFFF));
        send(mc0, 16'hFFFF);
        send(mc1, 16'h0000);
        wait_ops(2, 200);
        if (obs_q.size() != 2) return;
        prod = obs_q[0].mc * obs_q[0].ser;
        vectors++;
        if (obs_q[0].ser !== 16'hFFFF || prod !== mc0 * 32'h0000FFFF) begin
            miscompares++;
            $display("FAIL ext_ones: ser=%h prod=%h, required ffff %h", obs_q[0].ser, prod, mc0 * 32'h0000FFFF);
        end
        prod = obs_q[1].mc * obs_q[1].ser;
        vectors++;
        if (obs_q[1].ser !== 16'h0000 || prod !== 32'h0) begin
            miscompares++;
            $display("FAIL ext_zeros: ser=%h prod=%h, required 0000 00000000", obs_q[1].ser, prod);
        end
        vectors++;
        if (stray != 0 || unstable != 0) begin
            miscompares++;
            $display("FAIL ext_gap: stray=%0d unstable=%0d, required 0 0", stray, unstable);
        end
    endtask

    task automatic test_stall();
        logic [MW-1:0] exp_mc;
        logic [PW-1:0] exp_mp;
        logic          rdy;
        int            stalled;
        bit            done;
        clear_books();
        send(16'h1111, 16'h2222);
        send(16'h3333, 16'h4444);
        stalled = 0;
        done = 1'b0;
        exp_mc = '0;
        exp_mp = '0;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            in_mcand  = MW'($urandom);
            in_mplier = PW'($urandom);
            rdy = in_ready;
            if (!rdy) stalled++;
            exp_mc = in_mcand;
            exp_mp = in_mplier;
            step();
            if (rdy) done = 1'b1;
        end
        in_valid = 1'b0;
        vectors++;
        if (!done || stalled < 1) begin
            miscompares++;
            $display("FAIL stall_wait: done=%b stalled=%0d, required 1 and >0", done, stalled);
        end
        wait_ops(3, 200);
        if (obs_q.size() != 3 || acc_q.size() != 3) return;
        vectors++;
        if (obs_q[2].mc !== exp_mc || obs_q[2].ser !== exp_mp) begin
            miscompares++;
            $display("FAIL stall_word: mc=%h ser=%h, required %h %h", obs_q[2].mc, obs_q[2].ser, exp_mc, exp_mp);
        end
        vectors++;
        if (acc_q[2].t != obs_q[1].t + 1) begin
            miscompares++;
            $display("FAIL stall_accept: edge %0d, required %0d", acc_q[2].t, obs_q[1].t + 1);
        end
    endtask

    task automatic test_random();
        logic [MW-1:0] ref_mc[$];
        logic [PW-1:0] ref_mp[$];
        logic [31:0]   p_obs;
        logic [31:0]   p_ref;
        int            n;
        clear_books();
        for (int i = 0; i < 1000; i++) begin
            ref_mc.push_back(MW'($urandom));
            ref_mp.push_back(PW'($urandom));
            send(ref_mc[i], ref_mp[i]);
            repeat ($urandom_range(0, 3)) step();
        end
        wait_ops(1000, 30000);
        n = (obs_q.size() < 1000) ? obs_q.size() : 1000;
        for (int i = 0; i < n; i++) begin
            p_obs = obs_q[i].mc * obs_q[i].ser;
            p_ref = ref_mc[i] * ref_mp[i];
            vectors++;
            if (p_obs !== p_ref || obs_q[i].mp !== ref_mp[i] || obs_q[i].ser !== ref_mp[i]) begin
                miscompares++;
                $display("FAIL rand_op%0d: prod=%h mp=%h ser=%h, required %h %h %h",
                         i, p_obs, obs_q[i].mp, obs_q[i].ser, p_ref, ref_mp[i], ref_mp[i]);
            end
        end
        vectors++;
        if (stray != 0 || unstable != 0 || overlap != 0 || start_cnt != 1000) begin
            miscompares++;
            $display("FAIL rand_protocol: stray=%0d unstable=%0d overlap=%0d starts=%0d, required 0 0 0 1000",
                     stray, unstable, overlap, start_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        step();
        step();
        test_reset();
        test_single();
        test_back_to_back();
        test_extremes();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
